// File: rtl/booth_pp_accumulator_pkg.sv
// booth_pp_accumulator_pkg
//   Shared MAC definitions for the Booth partial-product accumulator:
//   default widths, FSM state encoding and the +1/+2 correction constants
//   that complete the two's-complement negation of a Booth partial product.
package booth_pp_accumulator_pkg;

   localparam int DEF_ACC_W      = 12;
   localparam int DEF_MAX_DIGITS = 4;
   localparam int PP_W           = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The multiplier stage emits a one's-complement pp on negation; these
   // constants supply the missing LSB (x1 digit) or bit 1 (x2 digit).
   localparam logic [1:0] CORR_NONE = 2'd0;
   localparam logic [1:0] CORR_ONE  = 2'd1;
   localparam logic [1:0] CORR_TWO  = 2'd2;

endpackage

// File: rtl/booth_pp_accumulator_if.sv
// booth_pp_accumulator_if
//   Beat-in / product-out handshake bundle.
//   master : partial-product producer and product consumer
//   slave  : booth_pp_accumulator
//   pp_valid/pp_ready + pp, shift, negation, zero, pp_last : input beats
//   prod_valid/prod_ready + product, digit_err              : closed products
interface booth_pp_accumulator_if
   import booth_pp_accumulator_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) ();

   logic              pp_valid;
   logic              pp_ready;
   logic [PP_W-1:0]   pp;
   logic              shift;
   logic              negation;
   logic              zero;
   logic              pp_last;
   logic              prod_valid;
   logic              prod_ready;
   logic [ACC_W-1:0]  product;
   logic              digit_err;

   modport master (
      output pp_valid, pp, shift, negation, zero, pp_last, prod_ready,
      input  pp_ready, prod_valid, product, digit_err
   );

   modport slave (
      input  pp_valid, pp, shift, negation, zero, pp_last, prod_ready,
      output pp_ready, prod_valid, product, digit_err
   );

endinterface

// File: rtl/booth_term_correct.sv
// booth_term_correct
//   Combinational term builder: sign-extends a 5-bit Booth partial product
//   to ACC_W and adds the negation correction.
//   pp, shift, negation, zero : Booth digit encoding for this beat
//   term                      : corrected term, unshifted, ACC_W wide
module booth_term_correct
   import booth_pp_accumulator_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [PP_W-1:0]  pp,
   input  logic             shift,
   input  logic             negation,
   input  logic             zero,
   output logic [ACC_W-1:0] term
);

   logic [1:0] corr;

   always_comb begin
      corr = CORR_NONE;
      // A zero digit carries no magnitude, so its negation flag is moot.
      if (!zero && negation)
         corr = shift ? CORR_TWO : CORR_ONE;
      term = {{(ACC_W-PP_W){pp[PP_W-1]}}, pp} + ACC_W'(corr);
   end

endmodule

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
//   Accumulates radix-4 Booth partial-product beats into a signed product.
//   Digit k is weighted by 4^k; the product closes on pp_last or after
//   MAX_DIGITS beats (the latter flags digit_err).
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of booth_pp_accumulator_if
module booth_pp_accumulator
   import booth_pp_accumulator_pkg::*;
#(
   parameter int MAX_DIGITS = DEF_MAX_DIGITS,
   parameter int ACC_W      = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   booth_pp_accumulator_if.slave    bus
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  count;
   logic              err_q;

   logic              pp_ready;
   logic              prod_valid;
   logic              xfer;
   logic [CNT_W-1:0]  idx;
   logic [CNT_W-1:0]  idx_inc;
   logic              close;
   logic [ACC_W-1:0]  term;
   logic [ACC_W-1:0]  term_sh;
   logic [ACC_W-1:0]  acc_base;

   booth_term_correct #(.ACC_W(ACC_W)) u_term (
      .pp       (bus.pp),
      .shift    (bus.shift),
      .negation (bus.negation),
      .zero     (bus.zero),
      .term     (term)
   );

   assign xfer     = bus.pp_valid && pp_ready;
   // A beat taken in IDLE is always digit 0, whatever count was left over.
   assign idx      = (state == ST_IDLE) ? '0 : count;
   assign idx_inc  = idx + CNT_W'(1);
   assign close    = bus.pp_last || (idx_inc == CNT_W'(MAX_DIGITS));
   assign term_sh  = term << {idx, 1'b0};
   assign acc_base = (state == ST_IDLE) ? '0 : acc;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (xfer) state_nxt = close ? ST_DONE : ST_ACC;
         ST_ACC:  if (xfer && close) state_nxt = ST_DONE;
         ST_DONE: if (bus.prod_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // outputs
   always_comb begin
      pp_ready   = 1'b0;
      prod_valid = 1'b0;
      case (state)
         ST_IDLE, ST_ACC: pp_ready   = 1'b1;
         ST_DONE:         prod_valid = 1'b1;
         default: ;
      endcase
   end

   // accumulator, digit counter, error flag; all frozen outside a transfer
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc   <= '0;
         count <= '0;
         err_q <= 1'b0;
      end else if (xfer) begin
         acc   <= acc_base + term_sh;
         count <= idx_inc;
         err_q <= !bus.pp_last && (idx_inc == CNT_W'(MAX_DIGITS));
      end
   end

   assign bus.pp_ready   = pp_ready;
   assign bus.prod_valid = prod_valid;
   assign bus.product    = acc;
   assign bus.digit_err  = err_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
module tb_booth_pp_accumulator;
   import booth_pp_accumulator_pkg::*;

   localparam int ACC_W = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   booth_pp_accumulator_if #(.ACC_W(ACC_W)) bus ();

   booth_pp_accumulator #(.MAX_DIGITS(4), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Present one beat from a negedge, hold until accepted, then scramble the
   // payload with pp_valid low so ignored fields are exercised.
   task automatic send_beat(input logic [4:0] p, input logic neg, input logic sh,
                            input logic z, input logic last);
      int n;
      @(negedge clk);
      bus.pp = p; bus.negation = neg; bus.shift = sh; bus.zero = z;
      bus.pp_last = last; bus.pp_valid = 1'b1;
      n = 0;
      while (bus.pp_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (n >= 20) begin
         miscompares++;
         $display("FAIL beat_accept_timeout: pp_ready=%b after %0d cycles, required 1", bus.pp_ready, n);
      end
      @(posedge clk);
      #1;
      bus.pp_valid = 1'b0;
      bus.pp = 5'($urandom); bus.negation = 1'($urandom); bus.shift = 1'($urandom);
      bus.zero = 1'($urandom); bus.pp_last = 1'($urandom);
   endtask

   task automatic handshake();
      @(negedge clk);
      bus.prod_ready = 1'b1;
      @(negedge clk);
      bus.prod_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.pp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_pp_ready: got %b want 1", bus.pp_ready); end
      vectors++;
      if (bus.prod_valid !== 1'b0) begin miscompares++; $display("FAIL reset_prod_valid: got %b want 0", bus.prod_valid); end
      vectors++;
      if (bus.product !== 12'd0) begin miscompares++; $display("FAIL reset_product: got %0d want 0", bus.product); end
      vectors++;
      if (bus.digit_err !== 1'b0) begin miscompares++; $display("FAIL reset_digit_err: got %b want 0", bus.digit_err); end
   endtask

   task automatic test_5x3();
      send_beat(5'b11010, 1'b1, 1'b0, 1'b0, 1'b0);   // -6 + 1 = -5
      send_beat(5'b00101, 1'b0, 1'b0, 1'b0, 1'b1);   // 5 * 4 = 20
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b1) begin miscompares++; $display("FAIL 5x3_latency: prod_valid=%b want 1", bus.prod_valid); end
      vectors++;
      if (bus.product !== 12'd15) begin miscompares++; $display("FAIL 5x3_product: got %0d want 15", $signed(bus.product)); end
      vectors++;
      if (bus.digit_err !== 1'b0) begin miscompares++; $display("FAIL 5x3_digit_err: got %b want 0", bus.digit_err); end
      vectors++;
      if (bus.pp_ready !== 1'b0) begin miscompares++; $display("FAIL 5x3_pp_ready_done: got %b want 0", bus.pp_ready); end
      handshake();
      vectors++;
      if (bus.prod_valid !== 1'b0 || bus.pp_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL 5x3_idle_after: prod_valid=%b pp_ready=%b want 0/1", bus.prod_valid, bus.pp_ready);
      end
   endtask

   task automatic test_7xm8();
      logic [ACC_W-1:0] exp;
      exp = 12'hFC8;                                  // -56
      send_beat(5'b00000, 1'b1, 1'b0, 1'b1, 1'b0);   // zero digit: 0
      send_beat(5'b10000, 1'b1, 1'b1, 1'b0, 1'b1);   // (-16 + 2) * 4 = -56
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b1) begin miscompares++; $display("FAIL 7xm8_valid: got %b want 1", bus.prod_valid); end
      vectors++;
      if (bus.product !== exp) begin miscompares++; $display("FAIL 7xm8_product: got %0d want -56", $signed(bus.product)); end
      handshake();
   endtask

   task automatic test_digit_err();
      for (int i = 0; i < 3; i++)
         send_beat(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b0) begin miscompares++; $display("FAIL derr_early_valid: got %b want 0", bus.prod_valid); end
      send_beat(5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b1) begin miscompares++; $display("FAIL derr_valid: got %b want 1", bus.prod_valid); end
      vectors++;
      if (bus.product !== 12'd85) begin miscompares++; $display("FAIL derr_product: got %0d want 85", $signed(bus.product)); end
      vectors++;
      if (bus.digit_err !== 1'b1) begin miscompares++; $display("FAIL derr_flag: got %b want 1", bus.digit_err); end
      handshake();
      // next product starts fresh and clears the flag
      send_beat(5'b00010, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      vectors++;
      if (bus.product !== 12'd2 || bus.digit_err !== 1'b0) begin
         miscompares++;
         $display("FAIL derr_next_product: product=%0d err=%b want 2/0", $signed(bus.product), bus.digit_err);
      end
      handshake();
   endtask

   task automatic test_hold();
      send_beat(5'b11010, 1'b1, 1'b0, 1'b0, 1'b0);
      send_beat(5'b00101, 1'b0, 1'b0, 1'b0, 1'b1);
      // offer a junk beat while DONE; it must not be taken
      bus.pp_valid = 1'b1;
      bus.pp = 5'b01111; bus.pp_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.product !== 12'd15 || bus.pp_ready !== 1'b0 || bus.prod_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_cycle%0d: product=%0d pp_ready=%b prod_valid=%b want 15/0/1",
                     i, $signed(bus.product), bus.pp_ready, bus.prod_valid);
         end
      end
      bus.pp_valid = 1'b0;
      handshake();
      vectors++;
      if (bus.prod_valid !== 1'b0 || bus.pp_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL hold_release: prod_valid=%b pp_ready=%b want 0/1", bus.prod_valid, bus.pp_ready);
      end
   endtask

   task automatic test_reset_mid();
      send_beat(5'b11010, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.prod_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_valid%0d: got %b want 0", i, bus.prod_valid); end
      end
      send_beat(5'b00011, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b1 || bus.product !== 12'd3) begin
         miscompares++;
         $display("FAIL rstmid_product: valid=%b product=%0d want 1/3", bus.prod_valid, $signed(bus.product));
      end
      handshake();
   endtask

   task automatic test_gaps();
      send_beat(5'b11010, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b0 || bus.pp_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL gaps_stall: prod_valid=%b pp_ready=%b want 0/1", bus.prod_valid, bus.pp_ready);
      end
      send_beat(5'b00101, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      vectors++;
      if (bus.prod_valid !== 1'b1 || bus.product !== 12'd15) begin
         miscompares++;
         $display("FAIL gaps_product: valid=%b product=%0d want 1/15", bus.prod_valid, $signed(bus.product));
      end
      handshake();
   endtask

   initial begin
      bus.pp_valid = 1'b0; bus.pp = '0; bus.shift = 1'b0; bus.negation = 1'b0;
      bus.zero = 1'b0; bus.pp_last = 1'b0; bus.prod_ready = 1'b0;
      test_reset();
      test_5x3();
      test_7xm8();
      test_digit_err();
      test_hold();
      test_reset_mid();
      test_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
